botao_passo: RTL

- Front-end stage that converts two raw, bouncy push-button inputs (up, down) into clean single-cycle step commands for the downstream up/down counter's acrescer/decrecer inputs.
- Per button: 2-FF synchroniser, debounce filter, press-edge pulse and optional hold-to-repeat.
- Simultaneous holds are arbitrated so the two outputs are never high together.

---
 rtl/botao_passo.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/botao_passo.sv
// Push-button front end: turns raw up/down buttons into clean, arbitrated
// single-cycle step pulses (acrescer/decrecer) with optional hold-to-repeat.

module botao_passo_canal #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic repeat_en,
  output logic held,
  output logic pulse
);

  localparam logic [7:0]  DEB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [1:0]  sync;
  logic [7:0]  cnt;
  logic        s;
  state_t      state, state_nx;
  logic [15:0] timer, timer_nx;

  assign s = sync[1];

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      held <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (s != held) begin
        if (cnt == DEB_LAST) begin
          held <= s;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // IDLE is only ever entered with held low, so a high level here is a rising edge.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    pulse    = 1'b0;
    case (state)
      IDLE: begin
        if (held) begin
          pulse    = 1'b1;
          timer_nx = '0;
          state_nx = DELAY;
        end
      end
      DELAY: begin
        if (!held) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (timer >= DELAY_LAST) begin
          timer_nx = DELAY_LAST;
          if (repeat_en) begin
            pulse    = 1'b1;
            timer_nx = '0;
            state_nx = REPEAT;
          end
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      REPEAT: begin
        if (!held) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (repeat_en) begin
          if (timer >= PERIOD_LAST) begin
            pulse    = 1'b1;
            timer_nx = '0;
          end else begin
            timer_nx = timer + 16'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

endmodule

module botao_passo #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic repeat_en,
  output logic acrescer,
  output logic decrecer,
  output logic up_held,
  output logic down_held
);

  logic up_pulse, down_pulse;

  botao_passo_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_up),
    .repeat_en(repeat_en),
    .held     (up_held),
    .pulse    (up_pulse)
  );

  botao_passo_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_down),
    .repeat_en(repeat_en),
    .held     (down_held),
    .pulse    (down_pulse)
  );

  // A pulse only passes while the opposite button is released, so both never fire together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acrescer <= 1'b0;
      decrecer <= 1'b0;
    end else begin
      acrescer <= up_pulse & ~down_held;
      decrecer <= down_pulse & ~up_held;
    end
  end

endmodule
